rr_sel_arb4: RTL and testbench
==============================

# rr_sel_arb4

Round-robin arbiter that produces the 2-bit select and one-hot grant for a downstream 4:1 single-bit mux. It sits directly upstream of the mux: four sources raise requests, one is granted at a time, and `sel` steers the granted source's data to the mux output. Grant tenure is bounded by a hold limit so no source can starve the others.

## Interface
- `MAX_HOLD`, 8: maximum consecutive cycles of one grant tenure; legal range 1..255.
- `clk`  in  1: clock; all logic is on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `req`  in  4: request per source; bit i corresponds to mux input i (0=a, 1=b, 2=c, 3=d).
- `done`  in  1: the currently granted source finished and releases its grant; ignored when not granted.
- `sel`  out  2: mux select, registered; encodes the index of the granted source.
- `gnt`  out  4: one-hot grant, registered; all-zero when idle.
- `busy`  out  1: registered; 1 while any grant is active (equals |gnt).

## Operation
- State machine has two states: IDLE and GRANT. Internal registers are `ptr[1:0]` (highest-priority index) and `cnt[7:0]` (tenure counter).
- Priority search: scan indices `ptr, ptr+1, ptr+2, ptr+3` mod 4 and pick the first with `req` set. Wrap-around from 3 to 0 is mandatory.
- IDLE: `gnt=0`, `busy=0`, and `sel` holds its last value. If `req!=0`, pick winner w, then next cycle state=GRANT, `gnt=1<<w`, `sel=w`, `cnt=0`.
- GRANT: a release occurs in any cycle where `done=1`, or `req[sel]=0`, or `cnt==MAX_HOLD-1`. Otherwise `cnt` increments.
- On release, `ptr` is loaded with `sel+1` (mod 4). The next winner is searched in the same cycle over the current `req`, starting at `sel+1`:
  - If a winner exists, the next cycle grants it with `cnt=0` and no idle bubble. The releasing source is eligible only at lowest priority, so it is re-granted only when it is the sole requester.
  - If no winner exists, the next cycle is IDLE with `gnt=0`.
- Grants are non-preemptive: a new request never interrupts a tenure before release.
- `MAX_HOLD=1` gives a grant of exactly one cycle, and rotation happens every cycle.
- Reset: state=IDLE, `gnt=0`, `sel=0`, `busy=0`, `ptr=0`, `cnt=0`. Reset overrides every other input in the same cycle, including in the middle of a grant.

## Timing
- Request-to-grant latency is 1 cycle: `req` sampled at edge k produces `gnt` and `sel` valid after edge k+1.
- Release-to-next-grant is 1 cycle: the release conditions sampled at edge k move `gnt` to the next winner after edge k+1.
- Maximum tenure is MAX_HOLD cycles of `gnt` high. Worst-case wait for a continuously requesting source is 3·MAX_HOLD cycles plus 1.
- `sel` and `gnt` change on the same edge and are never inconsistent. The downstream mux output is valid in every cycle where `busy=1`.
- `req` and `done` are sampled synchronously with no combinational path to any output.

## Test plan
- Single request: reset, then `req=4'b0100` held. After 1 cycle `gnt=4'b0100`, `sel=2`, `busy=1`. With MAX_HOLD=8, after 8 grant cycles the release re-grants source 2 back to back, with `gnt` never dropping.
- Fairness: `req=4'b1111` held with MAX_HOLD=2. Grants rotate 0,1,2,3,0 with exactly 2 cycles each and no gaps. Each source gets 8 cycles out of every 32.
- Wrap-around: `req=4'b1001` with the current grant on 3 releasing by `done`. Next grant is 0, then 3, alternately.
- Early release: grant on 1, pulse `done` for one cycle at tenure cycle 2 while `req=4'b1110`. Next cycle `gnt=4'b0100`, `sel=2`, `cnt` restarts at 0. Also drop `req[sel]` with other requests at 0: next cycle `gnt=0`, `busy=0`, `sel` holds.
- Reset mid-grant: assert `rst` during tenure cycle 3 of source 2. Next cycle `gnt=0`, `sel=0`, `busy=0`. Release `rst` with `req=4'b1111`: the first grant is source 0.
- MAX_HOLD=1 with `req=4'b0011`: the grant alternates 0,1,0,1 on every cycle and `busy` stays 1.

Source files
------------

// File: rtl/rr_sel_arb4.sv
// ---------------------------------------------------------------------------
// rr_sel_arb4 -- four-source round-robin arbiter feeding a 4:1 mux.
//
// One source at a time holds the grant. A tenure ends on done, on the granted
// source dropping its request, or after MAX_HOLD cycles. The next winner is
// then chosen by a rotating-priority search that starts just after the
// releasing source. Every output is registered.
//
// Ports
//   clk   in   1  rising-edge clock
//   rst   in   1  synchronous active-high reset
//   req   in   4  request per source (bit i -> mux input i)
//   done  in   1  granted source releases its grant (ignored while idle)
//   sel   out  2  mux select = index of the granted source (holds when idle)
//   gnt   out  4  one-hot grant, zero when idle
//   busy  out  1  high while a grant is active (equals |gnt)
// ---------------------------------------------------------------------------
module rr_sel_arb4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       busy
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Counter value of the last cycle a tenure may last.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [1:0] ptr_r;
  logic [1:0] ptr_nxt_s;
  logic [7:0] cnt_r;
  logic [7:0] cnt_nxt_s;
  logic [1:0] owner_nxt_s;
  logic [2:0] pick_s;
  logic       release_s;
  logic [1:0] sel_r;
  logic [3:0] gnt_r;
  logic       busy_r;
  logic [1:0] sel_nxt_s;
  logic [3:0] gnt_nxt_s;
  logic       busy_nxt_s;

  // Rotating-priority search. Returns {found, index}. The loop walks from the
  // lowest-priority slot to the highest so the highest-priority hit is the
  // last one written.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // State and internal register update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ptr_r   <= 2'd0;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic: release detection, winner search, tenure counting.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    cnt_nxt_s   = cnt_r;
    owner_nxt_s = sel_r;
    release_s   = 1'b0;
    pick_s      = 3'b000;
    case (state_r)
      ST_IDLE: begin
        pick_s = rr_pick(req, ptr_r);
        if (pick_s[2]) begin
          state_nxt_s = ST_GRANT;
          owner_nxt_s = pick_s[1:0];
          cnt_nxt_s   = 8'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        release_s = done | ~req[sel_r] | (cnt_r == HOLD_LAST);
        if (release_s) begin
          // Searching from sel+1 leaves the releasing source at the lowest
          // priority, so it only wins back when nobody else is asking.
          ptr_nxt_s = sel_r + 2'd1;
          pick_s    = rr_pick(req, sel_r + 2'd1);
          cnt_nxt_s = 8'd0;
          if (pick_s[2]) begin
            state_nxt_s = ST_GRANT;
            owner_nxt_s = pick_s[1:0];
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          cnt_nxt_s = cnt_r + 8'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output decode for the coming cycle; sel keeps its value while idle.
  always_comb begin
    sel_nxt_s  = sel_r;
    gnt_nxt_s  = 4'b0000;
    busy_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_GRANT: begin
        sel_nxt_s  = owner_nxt_s;
        gnt_nxt_s  = 4'b0001 << owner_nxt_s;
        busy_nxt_s = 1'b1;
      end
      ST_IDLE: begin
        sel_nxt_s  = sel_r;
        gnt_nxt_s  = 4'b0000;
        busy_nxt_s = 1'b0;
      end
      default: begin
        sel_nxt_s  = sel_r;
        gnt_nxt_s  = 4'b0000;
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // Output registers: sel and gnt load on the same edge so they never disagree.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_r  <= 2'd0;
      gnt_r  <= 4'b0000;
      busy_r <= 1'b0;
    end else begin
      sel_r  <= sel_nxt_s;
      gnt_r  <= gnt_nxt_s;
      busy_r <= busy_nxt_s;
    end
  end

  assign sel  = sel_r;
  assign gnt  = gnt_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_rr_sel_arb4.sv
// ---------------------------------------------------------------------------
// tb_rr_sel_arb4 -- three arbiters (MAX_HOLD 8, 2, 1) share one stimulus
// stream. Every cycle each output is compared with a behavioural model that
// tracks the current owner as an integer; directed steps additionally check
// hand-derived constants.
// ---------------------------------------------------------------------------
module tb_rr_sel_arb4;

  logic           clk;
  logic           rst;
  logic [3:0]     req;
  logic           done;
  logic [2:0][1:0] sel_a;
  logic [2:0][3:0] gnt_a;
  logic [2:0]      busy_a;

  int checks_total;
  int checks_passed;

  // Model state per instance: owner is -1 while idle.
  int hold  [3];
  int m_own [3];
  int m_ptr [3];
  int m_cnt [3];
  int m_sel [3];

  rr_sel_arb4 #(.MAX_HOLD(8)) u_h8 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .sel(sel_a[0]), .gnt(gnt_a[0]), .busy(busy_a[0])
  );
  rr_sel_arb4 #(.MAX_HOLD(2)) u_h2 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .sel(sel_a[1]), .gnt(gnt_a[1]), .busy(busy_a[1])
  );
  rr_sel_arb4 #(.MAX_HOLD(1)) u_h1 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .sel(sel_a[2]), .gnt(gnt_a[2]), .busy(busy_a[2])
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // First requesting index scanning start, start+1, ... mod 4; -1 if none.
  function automatic int search(input logic [3:0] r, input int start);
    for (int off = 0; off < 4; off++) begin
      if (r[(start + off) % 4]) return (start + off) % 4;
    end
    return -1;
  endfunction

  // Advance the model of instance k by one clock with the given inputs.
  task automatic model_step(input int k, input logic [3:0] r, input logic d, input logic rs);
    int w;
    if (rs) begin
      m_own[k] = -1; m_sel[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0;
    end else if (m_own[k] < 0) begin
      w = search(r, m_ptr[k]);
      if (w >= 0) begin
        m_own[k] = w; m_sel[k] = w; m_cnt[k] = 0;
      end
    end else if (d || !r[m_own[k]] || (m_cnt[k] + 1 >= hold[k])) begin
      m_ptr[k] = (m_own[k] + 1) % 4;
      w = search(r, m_ptr[k]);
      m_cnt[k] = 0;
      if (w >= 0) begin
        m_own[k] = w; m_sel[k] = w;
      end else begin
        m_own[k] = -1;
      end
    end else begin
      m_cnt[k] = m_cnt[k] + 1;
    end
  endtask

  // One clock: apply inputs, update the model, check all instances after the edge.
  task automatic cyc(input logic [3:0] r, input logic d, input logic rs);
    req = r; done = d; rst = rs;
    for (int k = 0; k < 3; k++) model_step(k, r, d, rs);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("gnt[h%0d]", hold[k]), 32'(gnt_a[k]),
          (m_own[k] < 0) ? 32'd0 : (32'd1 << m_own[k]));
      chk($sformatf("sel[h%0d]", hold[k]), 32'(sel_a[k]), 32'(m_sel[k]));
      chk($sformatf("busy[h%0d]", hold[k]), 32'(busy_a[k]), (m_own[k] < 0) ? 32'd0 : 32'd1);
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; req = 4'b0000; done = 1'b0;
    checks_total = 0; checks_passed = 0;
    hold[0] = 8; hold[1] = 2; hold[2] = 1;
    for (int k = 0; k < 3; k++) begin
      m_own[k] = -1; m_ptr[k] = 0; m_cnt[k] = 0; m_sel[k] = 0;
    end

    // Reset state.
    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0000, 1'b0, 1'b1);
    chk("reset_gnt", 32'(gnt_a[0]), 32'h0);
    chk("reset_sel", 32'(sel_a[0]), 32'h0);
    chk("reset_busy", 32'(busy_a[0]), 32'h0);

    // Single request on source 2: grant after one cycle, never drops.
    cyc(4'b0100, 1'b0, 1'b0);
    chk("single_gnt", 32'(gnt_a[0]), 32'h4);
    chk("single_sel", 32'(sel_a[0]), 32'h2);
    for (int i = 0; i < 12; i++) begin
      cyc(4'b0100, 1'b0, 1'b0);
      chk("single_hold_gnt", 32'(gnt_a[0]), 32'h4);
      chk("single_hold_busy", 32'(busy_a[0]), 32'h1);
    end

    // Fairness with MAX_HOLD=2: 0,0,1,1,2,2,3,3,... no gaps.
    cyc(4'b0000, 1'b0, 1'b1);
    for (int j = 0; j < 32; j++) begin
      cyc(4'b1111, 1'b0, 1'b0);
      chk("fair_gnt", 32'(gnt_a[1]), 32'd1 << ((j / 2) % 4));
    end

    // Wrap-around: grant on 3 releasing by done alternates 0,3,0,...
    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b1000, 1'b0, 1'b0);
    chk("wrap_start", 32'(gnt_a[0]), 32'h8);
    for (int j = 0; j < 4; j++) begin
      cyc(4'b1001, 1'b1, 1'b0);
      chk("wrap_gnt", 32'(gnt_a[0]), (j % 2 == 0) ? 32'h1 : 32'h8);
    end

    // Early release by done at tenure cycle 2 of source 1.
    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0010, 1'b0, 1'b0);
    cyc(4'b1110, 1'b0, 1'b0);
    cyc(4'b1110, 1'b0, 1'b0);
    cyc(4'b1110, 1'b1, 1'b0);
    chk("early_gnt", 32'(gnt_a[0]), 32'h4);
    chk("early_sel", 32'(sel_a[0]), 32'h2);
    // Dropping req[sel] with nothing else pending goes idle, sel holds.
    cyc(4'b0000, 1'b0, 1'b0);
    chk("drop_gnt", 32'(gnt_a[0]), 32'h0);
    chk("drop_busy", 32'(busy_a[0]), 32'h0);
    chk("drop_sel", 32'(sel_a[0]), 32'h2);

    // Reset in the middle of a tenure on source 2.
    cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b0100, 1'b0, 1'b1);
    chk("midrst_gnt", 32'(gnt_a[0]), 32'h0);
    chk("midrst_sel", 32'(sel_a[0]), 32'h0);
    chk("midrst_busy", 32'(busy_a[0]), 32'h0);
    cyc(4'b1111, 1'b0, 1'b0);
    chk("postrst_gnt", 32'(gnt_a[0]), 32'h1);

    // MAX_HOLD=1 with two requesters alternates every cycle.
    cyc(4'b0000, 1'b0, 1'b1);
    for (int j = 0; j < 8; j++) begin
      cyc(4'b0011, 1'b0, 1'b0);
      chk("h1_gnt", 32'(gnt_a[2]), (j % 2 == 0) ? 32'h1 : 32'h2);
      chk("h1_busy", 32'(busy_a[2]), 32'h1);
    end

    // Randomized traffic against the model.
    for (int j = 0; j < 3000; j++) begin
      cyc(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 99) == 0));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
